// File: rtl/booth_mul_sched.sv
// Sequential radix-2 Booth multiplier shared by two requesters under round-robin
// arbitration; one add/subtract-and-shift step per clock, result tagged with requester id.
module booth_mul_sched #(
  parameter  int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req0_valid,
  output logic               req0_ready,
  input  logic [WIDTH-1:0]   req0_mplr,
  input  logic [WIDTH-1:0]   req0_mcnd,
  input  logic               req1_valid,
  output logic               req1_ready,
  input  logic [WIDTH-1:0]   req1_mplr,
  input  logic [WIDTH-1:0]   req1_mcnd,
  input  logic               abort,
  output logic               busy,
  output logic               res_valid,
  input  logic               res_ready,
  output logic               res_id,
  output logic [2*WIDTH-1:0] res_product
);

  typedef enum logic [1:0] {IDLE, ITER, DONE} state_t;

  state_t             state;
  logic [WIDTH:0]     a_reg;
  logic [WIDTH:0]     m_reg;
  logic [WIDTH-1:0]   q_reg;
  logic               q_1;
  logic [CNT_W-1:0]   count;
  logic               cur_id;
  logic               last_grant;

  logic               grant0;
  logic               grant1;
  logic [WIDTH-1:0]   sel_mplr;
  logic [WIDTH-1:0]   sel_mcnd;
  logic [WIDTH:0]     a_sum;
  logic [WIDTH:0]     a_shift;
  logic [WIDTH-1:0]   q_shift;

  // On contention the requester that was not granted last time wins.
  assign grant0   = req0_valid & (~req1_valid | last_grant);
  assign grant1   = req1_valid & (~req0_valid | ~last_grant);
  assign sel_mplr = grant1 ? req1_mplr : req0_mplr;
  assign sel_mcnd = grant1 ? req1_mcnd : req0_mcnd;

  // Gated by rst_n so no ready is seen while reset is held.
  assign req0_ready = rst_n & (state == IDLE) & grant0;
  assign req1_ready = rst_n & (state == IDLE) & grant1;
  assign busy       = (state != IDLE);

  // A carries one guard bit so subtracting the most-negative multiplicand cannot overflow.
  always_comb begin
    a_sum = a_reg;
    case ({q_reg[0], q_1})
      2'b01:   a_sum = a_reg + m_reg;
      2'b10:   a_sum = a_reg - m_reg;
      default: a_sum = a_reg;
    endcase
  end

  assign a_shift = {a_sum[WIDTH], a_sum[WIDTH:1]};
  assign q_shift = {a_sum[0], q_reg[WIDTH-1:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      a_reg       <= '0;
      m_reg       <= '0;
      q_reg       <= '0;
      q_1         <= 1'b0;
      count       <= '0;
      cur_id      <= 1'b0;
      last_grant  <= 1'b1;
      res_valid   <= 1'b0;
      res_id      <= 1'b0;
      res_product <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant0 | grant1) begin
            a_reg      <= '0;
            q_reg      <= sel_mplr;
            q_1        <= 1'b0;
            m_reg      <= {sel_mcnd[WIDTH-1], sel_mcnd};
            count      <= '0;
            cur_id     <= grant1;
            last_grant <= grant1;
            state      <= ITER;
          end
        end
        ITER: begin
          if (abort) begin
            state <= IDLE;
          end else begin
            a_reg <= a_shift;
            q_reg <= q_shift;
            q_1   <= q_reg[0];
            count <= count + CNT_W'(1);
            if (count == CNT_W'(WIDTH - 1)) begin
              state       <= DONE;
              res_product <= {a_shift[WIDTH-1:0], q_shift};
              res_id      <= cur_id;
              res_valid   <= 1'b1;
            end
          end
        end
        DONE: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/booth_mul_sched.md
Name: booth_mul_sched

Overview:
- Sequential, arbitrated Booth multiplier engine. Runs one radix-2 Booth add/subtract-and-shift step per clock, so signed WIDTH x WIDTH products need no unrolled step chain.
- Two requester ports share the engine under round-robin arbitration.
- Each result is returned with the ID of the requester that issued it, over a valid/ready handshake.

Parameters:
- WIDTH, 8, operand width in bits (signed two's complement); product is 2*WIDTH bits.
- CNT_W, $clog2(WIDTH+1), width of the iteration counter; derived, not overridden.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req0_valid  in  1  requester 0 has an operand pair.
- req0_ready  out  1  requester 0 operands accepted this cycle.
- req0_mplr  in  WIDTH  requester 0 multiplier (signed).
- req0_mcnd  in  WIDTH  requester 0 multiplicand (signed).
- req1_valid, req1_ready, req1_mplr, req1_mcnd: same as requester 0, for requester 1.
- abort  in  1  synchronous abort of an in-flight multiply.
- busy  out  1  high in any state other than IDLE.
- res_valid  out  1  product available.
- res_ready  in  1  consumer takes product.
- res_id  out  1  requester that issued the product.
- res_product  out  2*WIDTH  signed product.

Behaviour:
- States: IDLE, ITER, DONE.
- Reset (async, rst_n low):
  - State goes to IDLE.
  - Outputs: res_valid=0, res_product=0, res_id=0, busy=0, req0_ready=0, req1_ready=0.
  - Internal: A=0, Q=0, q_1=0, M=0, count=0.
  - last_grant=1, so requester 0 wins the first contention.
- Arbitration (combinational, IDLE only):
  - If exactly one reqK_valid is high, grant K.
  - If both are high, grant the requester that is not last_grant.
  - reqK_ready = (state==IDLE) & granted K. Both readies are 0 outside IDLE.
  - A ready never asserts without the matching valid.
- Acceptance edge (IDLE, granted reqK_valid):
  - Load A=0 (WIDTH+1 bits), Q=reqK_mplr, q_1=0.
  - Load M = reqK_mcnd sign-extended to WIDTH+1 bits.
  - Load count=0, captured id=K, last_grant=K.
  - Go to ITER.
- ITER step, one per cycle, on {Q[0], q_1}:
  - 01: A = A + M.
  - 10: A = A - M.
  - 00 or 11: A unchanged.
  - Then arithmetic right shift of {A,Q,q_1} by one; the MSB of A is replicated.
  - count increments.
  - On the edge where count reaches WIDTH-1 (the WIDTH-th step), go to DONE.
  - At that edge latch res_product = {A[WIDTH-1:0], Q} (post-shift values), latch res_id, set res_valid=1.
- Accumulator width: A is WIDTH+1 bits so that subtracting the most-negative multiplicand (-2^(WIDTH-1)) does not overflow. All add/sub is modulo 2^(WIDTH+1).
- Latency: res_valid rises exactly WIDTH cycles after the acceptance edge.
- DONE:
  - res_valid, res_product and res_id hold stable until res_valid & res_ready.
  - On that edge: res_valid=0, go to IDLE.
  - The next acceptance can occur no earlier than the following edge. Minimum initiation interval is WIDTH+2 cycles with res_ready held high.
- Back-pressure: res_ready low in DONE stalls indefinitely. Requesters see ready=0 throughout.
- abort:
  - In ITER: go to IDLE next edge, no result produced, last_grant keeps the aborted requester.
  - In IDLE: ignored; acceptance proceeds.
  - In DONE: ignored; the result is still delivered.
  - Simultaneous abort and res_ready in DONE: normal delivery.
- Input changes: requester operand changes after acceptance do not affect the in-flight product.
- Mid-operation reset (rst_n low in any state):
  - Immediate return to reset values; the in-flight product is lost.
  - No res_valid glitch after release.
- busy = (state != IDLE).

Test Plan:
- Single request, WIDTH=8: req0 mplr=7, mcnd=-3, res_ready=1 -> res_valid 8 cycles after accept, res_product=0xFFEB (-21), res_id=0.
- Corner operands, one after another:
  - -128 x -128 -> 0x4000.
  - -128 x 127 -> 0xC080.
  - 0 x -5 -> 0x0000.
  - -1 x -1 -> 0x0001.
- Contention:
  - Both valid from reset with req0 (5,6) and req1 (-2,9) -> req0 served first (product 30, id 0), then req1 (product 0xFFEE = -18, id 1).
  - Hold both valid for 4 transactions -> ids alternate 0,1,0,1.
- Back-pressure: res_ready low 5 cycles after res_valid -> product and id stable; req0_ready and req1_ready stay 0; IDLE entered on the edge after res_ready rises.
- Abort: assert abort at the 3rd ITER cycle -> busy falls next edge, no res_valid; a resubmitted 3 x 4 yields 12.
- Reset: pull rst_n low mid-ITER -> all outputs 0 immediately; after release, req1 alone (-7, 7) returns 0xFFCF (-49), id 1.
